// File: rtl/decade_sequencer_pkg.sv
// Shared types for the decade sequencer: FSM state encoding.
// Optional load feature is enabled with DECADE_SEQUENCER_LOAD_EN.
package decade_sequencer_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StPause = 2'd2,
        StDone  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/decade_digit.sv
// Single modulo-MODULO digit with enable, clear, load (out-of-range loads as 0) and
// terminal-count flag.
module decade_digit #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned MODULO = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    output logic [WIDTH-1:0] q,
    output logic             tc
);

    // One extra bit so MODULO == 2**WIDTH still compares correctly.
    localparam logic [WIDTH:0]   ModExt = (WIDTH + 1)'(MODULO);
    localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULO - 1);

    logic [WIDTH-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (ld) begin
            q_d = ({1'b0, ld_val} >= ModExt) ? '0 : ld_val;
        end else if (en) begin
            q_d = tc ? '0 : q_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q  = q_q;
    assign tc = (q_q == MaxVal);

endmodule

// File: rtl/parameterized_decade_sequencer.sv
// Cascaded decade counter with IDLE/RUN/PAUSE/DONE control and match detection.
// Define DECADE_SEQUENCER_LOAD_EN to add the load/load_val ports.
module parameterized_decade_sequencer
    import decade_sequencer_pkg::*;
#(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned MODULO = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    clear,
    input  logic                    oneshot,
    input  logic [DIGITS*WIDTH-1:0] match_val,
`ifdef DECADE_SEQUENCER_LOAD_EN
    input  logic                    load,
    input  logic [DIGITS*WIDTH-1:0] load_val,
`endif
    output logic [DIGITS*WIDTH-1:0] count,
    output logic                    carry_out,
    output logic                    match,
    output logic                    busy,
    output logic                    done
);

    localparam logic [WIDTH:0] ModExt = (WIDTH + 1)'(MODULO);

    seq_state_e state_q, state_d;
    logic                    adv, clr_cnt, ld_cnt, load_req, mv_valid;
    logic [DIGITS-1:0]       en, tc;
    logic [DIGITS*WIDTH-1:0] load_bus;

`ifdef DECADE_SEQUENCER_LOAD_EN
    assign load_req = load;
    assign load_bus = load_val;
`else
    assign load_req = 1'b0;
    assign load_bus = '0;
`endif

    // Ripple enable: digit k advances only when every lower digit is at terminal count.
    always_comb begin
        en[0] = adv;
        for (int i = 1; i < DIGITS; i++) begin
            en[i] = en[i-1] & tc[i-1];
        end
    end

    // A compare value with any out-of-range digit can never match.
    always_comb begin
        mv_valid = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if ({1'b0, match_val[i*WIDTH +: WIDTH]} >= ModExt) begin
                mv_valid = 1'b0;
            end
        end
    end

    assign match     = mv_valid && (count == match_val);
    assign carry_out = (state_q == StRun) && (&tc);
    assign busy      = (state_q == StRun);
    assign done      = (state_q == StDone);

    always_comb begin
        state_d = state_q;
        adv     = 1'b0;
        clr_cnt = 1'b0;
        ld_cnt  = 1'b0;
        if (clear) begin
            state_d = StIdle;
            clr_cnt = 1'b1;
        end else if (load_req && (state_q != StRun)) begin
            ld_cnt = 1'b1;
            if (state_q == StDone) begin
                state_d = StIdle;
            end
        end else begin
            case (state_q)
                StIdle: if (start) state_d = StRun;
                StRun: begin
                    if (stop) begin
                        state_d = StPause;
                    end else if (oneshot && match) begin
                        state_d = StDone;
                    end else begin
                        adv = 1'b1;
                    end
                end
                StPause: if (start) state_d = StRun;
                StDone: begin
                    if (start) begin
                        state_d = StRun;
                        clr_cnt = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        decade_digit #(
            .WIDTH  (WIDTH),
            .MODULO (MODULO)
        ) u_digit (
            .clk    (clk),
            .rst_n  (rst_n),
            .en     (en[g]),
            .clr    (clr_cnt),
            .ld     (ld_cnt),
            .ld_val (load_bus[g*WIDTH +: WIDTH]),
            .q      (count[g*WIDTH +: WIDTH]),
            .tc     (tc[g])
        );
    end

endmodule

// File: tb/tb_parameterized_decade_sequencer.sv
// Self-checking bench for parameterized_decade_sequencer (DIGITS=2, MODULO=10).
// Load scenarios are exercised when DECADE_SEQUENCER_LOAD_EN is defined.
module tb_parameterized_decade_sequencer;

    localparam int unsigned DIGITS = 2;
    localparam int unsigned WIDTH  = 4;
    localparam int unsigned MODULO = 10;

    logic       clk = 1'b0;
    logic       rst_n, start, stop, clear, oneshot;
    logic [7:0] match_val, count;
    logic       carry_out, match, busy, done;
    logic       load;
    logic [7:0] load_val;

    always #5 clk = ~clk;

    parameterized_decade_sequencer #(
        .DIGITS (DIGITS),
        .WIDTH  (WIDTH),
        .MODULO (MODULO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .clear     (clear),
        .oneshot   (oneshot),
        .match_val (match_val),
`ifdef DECADE_SEQUENCER_LOAD_EN
        .load      (load),
        .load_val  (load_val),
`endif
        .count     (count),
        .carry_out (carry_out),
        .match     (match),
        .busy      (busy),
        .done      (done)
    );

    typedef struct packed {
        logic [7:0] cnt;
        logic       carry;
        logic       mat;
        logic       bsy;
        logic       dn;
    } exp_t;

    typedef struct {
        bit         start;
        bit         stop;
        bit         clear;
        bit         oneshot;
        logic [7:0] mv;
        exp_t       ex;
    } vec_t;

    exp_t sb_q[$];
    vec_t tbl[13];
    int   errors = 0;
    int   checks = 0;

    // Reference model: state 0..3 (IDLE/RUN/PAUSE/DONE), count as a plain integer 0..99.
    int m_state = 0;
    int m_cnt   = 0;

    function automatic logic [7:0] pack(int c);
        return {4'(c / 10), 4'(c % 10)};
    endfunction

    function automatic bit m_match(int c, logic [7:0] mv);
        return (mv[7:4] < 4'd10) && (mv[3:0] < 4'd10) && (pack(c) == mv);
    endfunction

    task automatic model_step();
        bit mm;
        int hi, lo;
        mm = m_match(m_cnt, match_val);
        if (!rst_n || clear) begin
            m_state = 0;
            m_cnt   = 0;
        end else if (load && m_state != 1) begin
            hi    = (load_val[7:4] >= 4'd10) ? 0 : int'(load_val[7:4]);
            lo    = (load_val[3:0] >= 4'd10) ? 0 : int'(load_val[3:0]);
            m_cnt = hi * 10 + lo;
            if (m_state == 3) m_state = 0;
        end else begin
            case (m_state)
                0: if (start) m_state = 1;
                1: begin
                    if (stop) m_state = 2;
                    else if (oneshot && mm) m_state = 3;
                    else m_cnt = (m_cnt + 1) % 100;
                end
                2: if (start) m_state = 1;
                default: if (start) begin
                    m_state = 1;
                    m_cnt   = 0;
                end
            endcase
        end
    endtask

    task automatic cycle(input bit use_tbl, input exp_t tex, input string name);
        exp_t e, got;
        model_step();
        e.cnt   = pack(m_cnt);
        e.carry = (m_state == 1) && (m_cnt == 99);
        e.mat   = m_match(m_cnt, match_val);
        e.bsy   = (m_state == 1);
        e.dn    = (m_state == 3);
        sb_q.push_back(use_tbl ? tex : e);
        @(posedge clk);
        #1;
        got = '{cnt: count, carry: carry_out, mat: match, bsy: busy, dn: done};
        e = sb_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL %s: got count=%h carry=%b match=%b busy=%b done=%b, want count=%h carry=%b match=%b busy=%b done=%b",
                     name, got.cnt, got.carry, got.mat, got.bsy, got.dn,
                     e.cnt, e.carry, e.mat, e.bsy, e.dn);
        end
    endtask

    task automatic run(input int n, input string name);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, name);
    endtask

    task automatic pulse(input string name);
        cycle(1'b0, '0, name);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    task automatic set_vec(input int i, input bit s, input bit p, input bit c, input bit o,
                           input logic [7:0] mv, input logic [7:0] cnt, input bit ca,
                           input bit m, input bit b, input bit d);
        tbl[i].start   = s;
        tbl[i].stop    = p;
        tbl[i].clear   = c;
        tbl[i].oneshot = o;
        tbl[i].mv      = mv;
        tbl[i].ex      = '{cnt: cnt, carry: ca, mat: m, bsy: b, dn: d};
    endtask

    initial begin
        //            start stop clr os  mv     count  ca m  b  d
        set_vec(0,  1, 0, 0, 1, 8'h03, 8'h00, 0, 0, 1, 0);
        set_vec(1,  0, 0, 0, 1, 8'h03, 8'h01, 0, 0, 1, 0);
        set_vec(2,  0, 0, 0, 1, 8'h03, 8'h02, 0, 0, 1, 0);
        set_vec(3,  0, 0, 0, 1, 8'h03, 8'h03, 0, 1, 1, 0);
        set_vec(4,  0, 0, 0, 1, 8'h03, 8'h03, 0, 1, 0, 1);
        set_vec(5,  0, 1, 0, 1, 8'h03, 8'h03, 0, 1, 0, 1);
        set_vec(6,  1, 0, 0, 1, 8'h03, 8'h00, 0, 0, 1, 0);
        set_vec(7,  1, 1, 0, 1, 8'h03, 8'h00, 0, 0, 0, 0);
        set_vec(8,  1, 0, 0, 1, 8'h03, 8'h00, 0, 0, 1, 0);
        set_vec(9,  0, 0, 0, 1, 8'h03, 8'h01, 0, 0, 1, 0);
        set_vec(10, 1, 0, 1, 1, 8'h03, 8'h00, 0, 0, 0, 0);
        set_vec(11, 0, 1, 0, 1, 8'h00, 8'h00, 0, 1, 0, 0);
        set_vec(12, 0, 0, 0, 1, 8'h0A, 8'h00, 0, 0, 0, 0);

        rst_n = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0; oneshot = 1'b0;
        match_val = 8'hAA; load = 1'b0; load_val = 8'h00;

        // Reset held for two edges
        run(2, "reset");
        chk("reset_count", 32'(count), 32'h00);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_carry", 32'(carry_out), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            start     = tbl[i].start;
            stop      = tbl[i].stop;
            clear     = tbl[i].clear;
            oneshot   = tbl[i].oneshot;
            match_val = tbl[i].mv;
            cycle(1'b1, tbl[i].ex, $sformatf("vec%0d", i));
        end
        start = 1'b0; stop = 1'b0; clear = 1'b0;

        // Free-run through full wrap
        oneshot = 1'b0; match_val = 8'h50;
        start = 1'b1; pulse("fr_start"); start = 1'b0;
        run(99, "fr_run");
        chk("fr_count99", 32'(count), 32'h99);
        chk("fr_carry99", 32'(carry_out), 32'd1);
        pulse("fr_wrap");
        chk("fr_count_wrap", 32'(count), 32'h00);
        chk("fr_carry_wrap", 32'(carry_out), 32'd0);
        clear = 1'b1; pulse("fr_clear"); clear = 1'b0;

        // One-shot halts on match
        oneshot = 1'b1; match_val = 8'h25;
        start = 1'b1; pulse("os_start"); start = 1'b0;
        run(25, "os_run");
        chk("os_count25", 32'(count), 32'h25);
        chk("os_match", 32'(match), 32'd1);
        pulse("os_halt");
        chk("os_done", 32'(done), 32'd1);
        chk("os_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 10; i++) begin
            pulse("os_hold");
            chk("os_hold_count", 32'(count), 32'h25);
        end
        clear = 1'b1; pulse("os_clear"); clear = 1'b0;

        // Pause and resume
        oneshot = 1'b0; match_val = 8'hAA;
        start = 1'b1; pulse("pa_start"); start = 1'b0;
        run(7, "pa_run");
        chk("pa_count07", 32'(count), 32'h07);
        stop = 1'b1; pulse("pa_stop"); stop = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pulse("pa_hold");
            chk("pa_hold_count", 32'(count), 32'h07);
        end
        start = 1'b1; pulse("pa_resume"); start = 1'b0;
        pulse("pa_step");
        chk("pa_count08", 32'(count), 32'h08);
        start = 1'b1; stop = 1'b1; pulse("pa_both");
        start = 1'b0; stop = 1'b0;
        chk("pa_both_busy", 32'(busy), 32'd0);
        clear = 1'b1; pulse("pa_clear"); clear = 1'b0;

        // Clear and reset mid-run
        start = 1'b1; pulse("cl_start"); start = 1'b0;
        run(42, "cl_run");
        chk("cl_count42", 32'(count), 32'h42);
        clear = 1'b1; pulse("cl_clear"); clear = 1'b0;
        chk("cl_count", 32'(count), 32'h00);
        chk("cl_busy", 32'(busy), 32'd0);
        start = 1'b1; pulse("rs_start"); start = 1'b0;
        run(13, "rs_run");
        chk("rs_count13", 32'(count), 32'h13);
        rst_n = 1'b0; pulse("rs_reset"); rst_n = 1'b1;
        chk("rs_count", 32'(count), 32'h00);
        chk("rs_busy", 32'(busy), 32'd0);

        // One-shot with an unmatchable compare value keeps running
        oneshot = 1'b1; match_val = 8'hA5;
        start = 1'b1; pulse("iv_start"); start = 1'b0;
        run(120, "iv_run");
        chk("iv_busy", 32'(busy), 32'd1);
        chk("iv_done", 32'(done), 32'd0);
        clear = 1'b1; pulse("iv_clear"); clear = 1'b0;

`ifdef DECADE_SEQUENCER_LOAD_EN
        oneshot = 1'b0; match_val = 8'hAA;
        load = 1'b1; load_val = 8'h3A; pulse("ld_idle"); load = 1'b0;
        chk("ld_count30", 32'(count), 32'h30);
        chk("ld_idle_busy", 32'(busy), 32'd0);
        start = 1'b1; pulse("ld_start"); start = 1'b0;
        load = 1'b1; load_val = 8'h55; pulse("ld_run"); load = 1'b0;
        chk("ld_run_ignored", 32'(count), 32'h31);
        clear = 1'b1; pulse("ld_clear"); clear = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
